// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC register, loadable instruction memory, field decode, run/halt control.
// Latency: instruction and fields are combinational from the PC; the PC advances at each RUN-cycle edge.
// Backpressure: none; one instruction retires per RUN cycle, and loads are accepted only while IDLE.
module instruction_fetch_unit #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [31:0]       imem_wdata,
  input  logic              branch,
  input  logic              branch_cond,
  input  logic              jump,
  output logic [31:0]       instruction,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [5:0]        funct,
  output logic [15:0]       imm16,
  output logic [25:0]       jaddr,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              running,
  output logic              halted,
  output logic              fetch_err,
  output logic [31:0]       instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [31:0] imem [0:(1<<ADDR_W)-1];
  logic [31:0] fetch_word;
  logic [31:0] imm_ext;
  logic [31:0] target;
  logic        out_of_range;

  // Program memory: written only during the load phase, never cleared by reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  assign fetch_word  = imem[pc_q[ADDR_W+1:2]];
  // Outside RUN the decode stage sees a nop so downstream control stays inert.
  assign instruction = (state_q == S_RUN) ? fetch_word : 32'd0;

  assign opcode   = instruction[31:26];
  assign rs       = instruction[25:21];
  assign rt       = instruction[20:16];
  assign rd       = instruction[15:11];
  assign funct    = instruction[5:0];
  assign imm16    = instruction[15:0];
  assign jaddr    = instruction[25:0];

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign running     = (state_q == S_RUN);
  assign halted      = (state_q == S_HALT);
  assign fetch_err   = err_q;
  assign instr_count = cnt_q;

  assign imm_ext = {{14{imm16[15]}}, imm16, 2'b00};

  // Next-PC select: jump beats taken branch beats sequential; then range check.
  always_comb begin
    target = pc_plus4;
    if (jump) begin
      target = {pc_plus4[31:28], jaddr, 2'b00};
    end else if (branch && branch_cond) begin
      target = pc_plus4 + imm_ext;
    end
    out_of_range = ((target >> (ADDR_W + 2)) != 32'd0) || (target[1:0] != 2'b00);
  end

  // Control FSM: start/halt transitions, PC update and retired-instruction count.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (fetch_word == HALT_WORD) begin
          // The halt word is neither counted nor allowed to redirect the PC.
          state_d = S_HALT;
        end else begin
          if (cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
          end
          if (out_of_range) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end else begin
            pc_d = target;
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= 32'd0;
      cnt_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        imem_we = 1'b0;
  logic [7:0]  imem_waddr = 8'd0;
  logic [31:0] imem_wdata = 32'd0;
  logic        branch = 1'b0;
  logic        branch_cond = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] instruction;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic [31:0] pc, pc_plus4;
  logic        running, halted, fetch_err;
  logic [31:0] instr_count;

  int tests_run = 0;
  int tests_failed = 0;

  instruction_fetch_unit #(.ADDR_W(8), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .branch(branch), .branch_cond(branch_cond), .jump(jump),
    .instruction(instruction), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .funct(funct), .imm16(imm16), .jaddr(jaddr),
    .pc(pc), .pc_plus4(pc_plus4), .running(running), .halted(halted),
    .fetch_err(fetch_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    tick();
    imem_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic hard_reset();
    #1 reset = 1'b0;
    #3 reset = 1'b1;
    tick();
  endtask

  task automatic load_program_a();
    load(8'd0, 32'h2001_0005);
    load(8'd1, 32'h2002_0003);
    load(8'd2, 32'h0000_0000);
    load(8'd3, 32'hFFFF_FFFF);
  endtask

  // Steps program A from pc 0 to its halt word and checks the halted state.
  task automatic run_program_a(input string tag);
    logic [31:0] exp_pc [4] = '{32'd0, 32'd4, 32'd8, 32'd12};
    logic [5:0]  exp_op [4] = '{6'b001000, 6'b001000, 6'b000000, 6'b111111};
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (pc !== exp_pc[i]) begin tests_failed++; $display("FAIL %s_pc[%0d]: got %h expected %h", tag, i, pc, exp_pc[i]); end
      tests_run++; if (opcode !== exp_op[i]) begin tests_failed++; $display("FAIL %s_opcode[%0d]: got %b expected %b", tag, i, opcode, exp_op[i]); end
      tests_run++; if (instr_count !== 32'(i)) begin tests_failed++; $display("FAIL %s_count[%0d]: got %0d expected %0d", tag, i, instr_count, i); end
      tests_run++; if (running !== 1'b1) begin tests_failed++; $display("FAIL %s_running[%0d]: got %b expected 1", tag, i, running); end
      tick();
    end
    tests_run++; if (halted !== 1'b1 || running !== 1'b0) begin tests_failed++; $display("FAIL %s_halted: got halted=%b running=%b expected 1/0", tag, halted, running); end
    tests_run++; if (pc !== 32'd12) begin tests_failed++; $display("FAIL %s_halt_pc: got %h expected 0000000c", tag, pc); end
    tests_run++; if (instr_count !== 32'd3) begin tests_failed++; $display("FAIL %s_halt_count: got %0d expected 3", tag, instr_count); end
    tests_run++; if (instruction !== 32'd0 || fetch_err !== 1'b0) begin tests_failed++; $display("FAIL %s_halt_outputs: got instr=%h err=%b expected 0/0", tag, instruction, fetch_err); end
  endtask

  task automatic test_reset();
    #12;
    tests_run++; if (pc !== 32'd0 || pc_plus4 !== 32'd4) begin tests_failed++; $display("FAIL reset_pc: got pc=%h pc4=%h expected 0/4", pc, pc_plus4); end
    tests_run++; if (running !== 1'b0 || halted !== 1'b0 || fetch_err !== 1'b0) begin tests_failed++; $display("FAIL reset_state: got r=%b h=%b e=%b expected 000", running, halted, fetch_err); end
    tests_run++; if (instr_count !== 32'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
    tests_run++; if (instruction !== 32'd0 || opcode !== 6'd0 || jaddr !== 26'd0) begin tests_failed++; $display("FAIL reset_instr: got %h expected 0", instruction); end
    #1 reset = 1'b1;
    tick();
  endtask

  task automatic test_program_a();
    load(8'd0, 32'h2001_0005);
    load(8'd1, 32'h2002_0003);
    load(8'd2, 32'h0000_0000);
    // Last word written in the same cycle as start must be visible to the run.
    imem_we = 1'b1; imem_waddr = 8'd3; imem_wdata = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    imem_we = 1'b0; start = 1'b0;
    tests_run++; if (rt !== 5'd1 || imm16 !== 16'd5 || rs !== 5'd0) begin tests_failed++; $display("FAIL a_fields: got rs=%0d rt=%0d imm=%h expected 0/1/0005", rs, rt, imm16); end
    run_program_a("a");
    pulse_start();
    tests_run++; if (halted !== 1'b1 || pc !== 32'd12) begin tests_failed++; $display("FAIL a_halt_sticky: got halted=%b pc=%h expected 1/0000000c", halted, pc); end
  endtask

  task automatic test_branch();
    logic [31:0] exp_pc [6] = '{32'd0, 32'd4, 32'd8, 32'd4, 32'd8, 32'd12};
    logic        br [6]     = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        cond [6]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    hard_reset();
    load(8'd0, 32'h0000_0000);
    load(8'd1, 32'h0000_0000);
    load(8'd2, 32'h1000_FFFE);
    load(8'd3, 32'hFFFF_FFFF);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      tests_run++; if (pc !== exp_pc[i]) begin tests_failed++; $display("FAIL branch_pc[%0d]: got %h expected %h", i, pc, exp_pc[i]); end
      branch = br[i]; branch_cond = cond[i];
      tick();
      branch = 1'b0; branch_cond = 1'b0;
    end
    tests_run++; if (halted !== 1'b1 || instr_count !== 32'd5) begin tests_failed++; $display("FAIL branch_end: got halted=%b count=%0d expected 1/5", halted, instr_count); end
  endtask

  task automatic test_jump_priority();
    hard_reset();
    load(8'd0, 32'h0000_0000);
    load(8'd1, 32'h0800_0010);
    load(8'h10, 32'hFFFF_FFFF);
    pulse_start();
    tick();
    tests_run++; if (pc !== 32'd4 || jaddr !== 26'h10) begin tests_failed++; $display("FAIL jump_pre: got pc=%h jaddr=%h expected 4/10", pc, jaddr); end
    jump = 1'b1; branch = 1'b1; branch_cond = 1'b1;
    tick();
    jump = 1'b0; branch = 1'b0; branch_cond = 1'b0;
    tests_run++; if (pc !== 32'h40) begin tests_failed++; $display("FAIL jump_pc: got %h expected 00000040", pc); end
    tests_run++; if (instruction !== 32'hFFFF_FFFF || instr_count !== 32'd2) begin tests_failed++; $display("FAIL jump_target: got instr=%h count=%0d expected ffffffff/2", instruction, instr_count); end
    tick();
    tests_run++; if (halted !== 1'b1 || fetch_err !== 1'b0 || instr_count !== 32'd2) begin tests_failed++; $display("FAIL jump_halt: got h=%b e=%b count=%0d expected 1/0/2", halted, fetch_err, instr_count); end
  endtask

  task automatic test_out_of_range();
    hard_reset();
    load(8'd0, 32'h0800_0100);
    pulse_start();
    tests_run++; if (pc !== 32'd0 || jaddr !== 26'h100) begin tests_failed++; $display("FAIL oor_pre: got pc=%h jaddr=%h expected 0/100", pc, jaddr); end
    jump = 1'b1;
    tick();
    jump = 1'b0;
    tests_run++; if (halted !== 1'b1 || fetch_err !== 1'b1 || running !== 1'b0) begin tests_failed++; $display("FAIL oor_state: got h=%b e=%b r=%b expected 1/1/0", halted, fetch_err, running); end
    tests_run++; if (pc !== 32'd0 || instr_count !== 32'd1) begin tests_failed++; $display("FAIL oor_hold: got pc=%h count=%0d expected 0/1", pc, instr_count); end
    tick();
    tests_run++; if (pc !== 32'd0 || instr_count !== 32'd1 || fetch_err !== 1'b1) begin tests_failed++; $display("FAIL oor_after: got pc=%h count=%0d e=%b expected 0/1/1", pc, instr_count, fetch_err); end
  endtask

  task automatic test_load_lockout();
    hard_reset();
    load_program_a();
    pulse_start();
    imem_we = 1'b1; imem_waddr = 8'd1; imem_wdata = 32'hDEAD_BEEF;
    tick();
    imem_we = 1'b0;
    tests_run++; if (pc !== 32'd4 || instruction !== 32'h2002_0003) begin tests_failed++; $display("FAIL lock_run: got pc=%h instr=%h expected 4/20020003", pc, instruction); end
    hard_reset();
    tests_run++; if (instruction !== 32'd0 || running !== 1'b0) begin tests_failed++; $display("FAIL lock_idle: got instr=%h r=%b expected 0/0", instruction, running); end
    pulse_start();
    tick();
    tests_run++; if (pc !== 32'd4 || instruction !== 32'h2002_0003) begin tests_failed++; $display("FAIL lock_rerun: got pc=%h instr=%h expected 4/20020003", pc, instruction); end
  endtask

  task automatic test_reset_midrun();
    hard_reset();
    pulse_start();
    tick();
    tick();
    tests_run++; if (pc !== 32'd8 || instr_count !== 32'd2) begin tests_failed++; $display("FAIL mid_pre: got pc=%h count=%0d expected 8/2", pc, instr_count); end
    #1 reset = 1'b0;
    #1;
    tests_run++; if (pc !== 32'd0 || pc_plus4 !== 32'd4 || running !== 1'b0) begin tests_failed++; $display("FAIL mid_async: got pc=%h pc4=%h r=%b expected 0/4/0", pc, pc_plus4, running); end
    tests_run++; if (instr_count !== 32'd0 || instruction !== 32'd0) begin tests_failed++; $display("FAIL mid_clear: got count=%0d instr=%h expected 0/0", instr_count, instruction); end
    #2 reset = 1'b1;
    tick();
    pulse_start();
    run_program_a("rerun");
  endtask

  initial begin
    test_reset();
    test_program_a();
    test_branch();
    test_jump_priority();
    test_out_of_range();
    test_load_lockout();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front stage of the single-cycle datapath: owns the program counter and a loadable instruction memory, and presents the current instruction and its decoded fields. The 6-bit opcode goes straight into `control_unit`, and the remaining fields go to the register file, sign-extender and jump logic. The block takes `branch`/`jump` back from `control_unit` (with the ALU branch condition) to choose the next PC. It also provides a program-load phase, a start/halt state machine and a retired-instruction counter for benches.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction-memory word-address width (2^ADDR_W 32-bit words).
- `HALT_WORD`, default 32'hFFFF_FFFF: instruction encoding that stops fetch.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse; moves IDLE to RUN.
- `imem_we`, in, 1: program-load write enable; honoured only in IDLE.
- `imem_waddr`, in, ADDR_W: load word address.
- `imem_wdata`, in, 32: load word.
- `branch`, in, 1: from `control_unit`.
- `branch_cond`, in, 1: branch condition met (beq/bne already resolved by the ALU side).
- `jump`, in, 1: from `control_unit`.
- `instruction`, out, 32: current instruction.
- `opcode`, out, 6: instruction[31:26].
- `rs`, `rt`, `rd`, out, 5 each: [25:21], [20:16], [15:11].
- `funct`, out, 6: [5:0].
- `imm16`, out, 16: [15:0].
- `jaddr`, out, 26: [25:0].
- `pc`, out, 32: byte address of the current instruction.
- `pc_plus4`, out, 32: pc + 4.
- `running`, out, 1: state == RUN.
- `halted`, out, 1: state == HALT.
- `fetch_err`, out, 1: halted because the PC left the memory.
- `instr_count`, out, 32: instructions retired since reset.

## Operation
States and transitions:
- IDLE: after reset. Loads are accepted. `start` → RUN.
- RUN: one instruction retires per cycle.
  - → HALT when the current instruction == HALT_WORD.
  - → HALT with `fetch_err` = 1 when the next PC is out of range.
- HALT: terminal. Only `reset` leaves it; `start` is ignored.

Program memory:
- Imem is 2^ADDR_W × 32, with combinational read at index pc[ADDR_W+1:2].
- Writes are synchronous and occur only when IDLE and `imem_we` = 1; they are ignored in RUN and HALT.
- Contents are not cleared by reset.

Next PC in RUN (priority order):
1. `jump`: {pc_plus4[31:28], jaddr, 2'b00}.
2. `branch` && `branch_cond`: pc_plus4 + (sign-extended imm16 << 2), 32-bit wrap.
3. Otherwise: pc_plus4.

Address range:
- The next PC is out of range if bits [31:ADDR_W+2] ≠ 0 or bits [1:0] ≠ 0.
- In that case PC holds its value, the state becomes HALT and `fetch_err` = 1.

Outputs outside RUN:
- `instruction` = 0 (nop encoding), and all field outputs = 0.
- `pc` shows the held PC.

Counter:
- `instr_count` += 1 on each RUN cycle whose instruction ≠ HALT_WORD.
- It saturates at 32'hFFFF_FFFF.
- The HALT_WORD itself is not counted.

## Timing
Reset values (asynchronous, while `reset` = 0):
- pc = 0; `pc_plus4` = 4.
- State IDLE: `running` = 0, `halted` = 0, `fetch_err` = 0.
- `instr_count` = 0.
- `instruction` and all fields = 0.

Fetch and PC update:
- Latency is 0 cycles: `instruction` reflects imem[pc] combinationally in the same cycle.
- The PC register updates at the rising edge ending each RUN cycle.

Start and load:
- A `start` sampled at edge N gives `running` = 1 after edge N, and the instruction at pc = 0 is presented in cycle N+1.
- If `imem_we` and `start` are asserted in the same IDLE cycle, the write completes at that edge, so the first fetch sees the new word.

Halt:
- When HALT_WORD is fetched at edge M, `halted` = 1 after edge M and PC stays at the HALT_WORD address.
- The `branch`/`jump` inputs are ignored in that cycle.

Control inputs:
- `branch`/`jump` are don't-care outside RUN.
- When `jump` and `branch` are asserted together, `jump` wins.

Reset mid-run:
- Asserting reset mid-RUN returns the block to IDLE immediately (asynchronously) with pc = 0.
- The program is preserved, so a new `start` re-runs it.

## Test plan
- Reset/load/start: load words 0..3 = 0x20010005, 0x20020003, 0x00000000, 0xFFFFFFFF, then pulse `start` → pc steps 0, 4, 8, 12; `opcode` = 001000, 001000, 000000; `halted` = 1 with pc = 12 and `instr_count` = 3.
- Branch: at pc = 8 fetch 0x1000FFFE with `branch` = 1, `branch_cond` = 1 → next pc = 4. Repeat with `branch_cond` = 0 → next pc = 12.
- Jump priority: at pc = 4 fetch 0x08000010 with `jump` = 1 and `branch` = 1 → next pc = 0x40.
- Out of range, ADDR_W = 8: jump to word 0x100 (pc 0x400) → pc holds, `halted` = 1, `fetch_err` = 1, `instr_count` unchanged after that cycle.
- Load lockout: `imem_we` during RUN writing 0xDEADBEEF to word 1 → a read after reset and re-start shows the original word.
- Async reset mid-RUN at pc = 8 → pc = 0, `running` = 0 and `instr_count` = 0 without waiting for a clock edge; `start` re-executes an identical sequence.
